uart_tx_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that shares the SoC's single UART byte transmitter between up to eight byte-stream requesters, e.g. firmware console, boot monitor, debug tracer. It sits between the requesters and the transmitter's byte interface inside the SoC top. It forwards one requester's packet, delimited by a `last` flag, without interleaving. An optional watchdog reclaims the grant from a requester that stalls mid-packet.

---
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-atomic round-robin arbiter sharing one UART byte
// transmitter between NUM_REQ byte-stream requesters. A grant is held from
// the first byte of a packet until the byte flagged `last` is accepted.
// Optional mid-packet stall watchdog: define UART_TX_ARBITER_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   timeout_pulse
);

    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]         state_reg, state_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;  // index of the grant holder
    logic [IDX_W-1:0]   ptr_reg, ptr_next;      // last served requester

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    int unsigned        pick_cand;

    logic               owner_valid;
    logic               owner_last;
    logic               xfer;
    logic               expire;

    logic [7:0]         masked_data [NUM_REQ];

    // Per-lane passthrough: only the owner's lane reaches the transmitter
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign masked_data[gi] = req_data[8*gi +: 8] & {8{grant_reg[gi]}};
            assign req_ready[gi]   = grant_reg[gi] & tx_ready;
        end
    endgenerate

    // OR-combine masked lanes; all-zero when no grant is held
    always_comb begin
        tx_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            tx_data = tx_data | masked_data[i];
        end
    end

    assign owner_valid = |(req_valid & grant_reg);
    assign owner_last  = |(req_last & grant_reg);
    assign xfer        = owner_valid & tx_ready;
    assign tx_valid    = owner_valid;
    assign grant       = grant_reg;
    assign busy        = (state_reg == ST_GRANT);

    // Cyclic search starting after ptr; descending scan so the nearest
    // candidate (offset 1) is the final, winning assignment
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_cand  = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            pick_cand = (int'(ptr_reg) + k) % NUM_REQ;
            if (req_valid[IDX_W'(pick_cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(pick_cand);
            end
        end
    end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // Reclaim when the owner has been stalled for TIMEOUT_CYCLES cycles
    assign expire        = (state_reg == ST_GRANT) && !owner_valid &&
                           (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_pulse = expire;

    // Stall counter: held at zero while idle, so every new grant starts clean
    always_comb begin
        cnt_next = cnt_reg;
        if (state_reg == ST_IDLE || xfer || expire) begin
            cnt_next = '0;
        end else if (!owner_valid) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Stall counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
`else
    // No watchdog: grants end only on a transferred last byte. The
    // parameter term is constant-false and keeps the port list uniform.
    assign expire        = 1'b0;
    assign timeout_pulse = 1'b0 & (TIMEOUT_CYCLES < 2);
`endif

    // Arbitration and end-of-packet / reclaim state transitions
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_found) begin
                    state_next = ST_GRANT;
                    grant_next = NUM_REQ'(1) << pick_idx;
                    owner_next = pick_idx;
                end
            end
            default: begin
                if ((xfer && owner_last) || expire) begin
                    state_next = ST_IDLE;
                    grant_next = '0;
                    ptr_next   = owner_reg;
                end
            end
        endcase
    end

    // Arbiter state registers; ptr starts at the top so requester 0 wins first
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            grant_reg <= '0;
            owner_reg <= '0;
            ptr_reg   <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (3 requesters, TIMEOUT_CYCLES=8).
// A cycle-level reference model tracks owner/priority with plain integers
// and queued packets; one line is printed per accepted byte.
module tb_uart_tx_arbiter;

    localparam int NREQ = 3;
    localparam int TO   = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b0;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              timeout_pulse;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
        .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .grant(grant), .busy(busy),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    int m_owner = -1;
    int m_ptr   = NREQ - 1;
    int m_stall = 0;

    // Requester packet stores and stimulus controls
    logic [8:0] mem [NREQ][256];
    int head [NREQ];
    int tail [NREQ];
    int start_at [NREQ];
    int pause_at [NREQ];
    int pause_len [NREQ];
    int pause_cnt [NREQ];
    int sent [NREQ];
    int delivered [NREQ];
    int valid_pct  = 100;
    int txr_mode   = 0;
    int bp_lo      = 0;
    int rand_pause = 0;
    int phase_cyc  = 0;
    int dut_pulses = 0;

    task automatic new_phase();
        phase_cyc  = 0;
        dut_pulses = 0;
        rand_pause = 0;
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0; tail[i] = 0; start_at[i] = 0; pause_at[i] = -1;
            pause_len[i] = 0; pause_cnt[i] = 0; sent[i] = 0; delivered[i] = 0;
        end
    endtask

    task automatic add_packet(input int r, input int len);
        for (int b = 0; b < len; b++) begin
            mem[r][tail[r]] = {(b == len - 1), 8'($urandom_range(255))};
            tail[r]++;
        end
    endtask

    // Present new bytes; a requester already showing valid keeps it stable
    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i]) begin
                if (pause_cnt[i] > 0) begin
                    pause_cnt[i]--;
                end else if (head[i] < tail[i] && phase_cyc >= start_at[i] &&
                             $urandom_range(99) < valid_pct) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = mem[i][head[i]][7:0];
                    req_last[i]        = mem[i][head[i]][8];
                end
            end
        end
        case (txr_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ($urandom_range(3) != 0);
            default: tx_ready = !(phase_cyc >= bp_lo && phase_cyc < bp_lo + 5);
        endcase
    endtask

    // One clock: compare outputs at negedge, then advance model and stimulus
    task automatic cycle();
        logic [NREQ-1:0] e_grant, e_ready;
        logic            e_valid, e_pulse;
        logic [7:0]      e_data;
        int n_owner, n_ptr, n_stall, xi, c, g;
        @(negedge clock);
        n_owner = m_owner; n_ptr = m_ptr; n_stall = m_stall; xi = -1;
        e_grant = '0; e_ready = '0; e_valid = 1'b0; e_pulse = 1'b0; e_data = '0;
        if (m_owner < 0) begin
            n_stall = 0;
            for (int k = 1; k <= NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (req_valid[c]) begin
                    n_owner = c;
                    break;
                end
            end
        end else begin
            g       = m_owner;
            e_grant = NREQ'(1) << g;
            e_valid = req_valid[g];
            e_data  = req_data[8*g +: 8];
            e_ready = tx_ready ? e_grant : '0;
            if (req_valid[g] && tx_ready) begin
                xi      = g;
                n_stall = 0;
                if (req_last[g]) begin
                    n_owner = -1;
                    n_ptr   = g;
                end
            end else if (!req_valid[g]) begin
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                // this is the TO-th stalled cycle of the grant
                if (m_stall + 1 == TO) begin
                    e_pulse = 1'b1;
                    n_owner = -1;
                    n_ptr   = g;
                    n_stall = 0;
                end else begin
                    n_stall = m_stall + 1;
                end
`else
                n_stall = m_stall + 1;
`endif
            end
            check("tx_data", tx_data, e_data);
        end
        check("grant", grant, e_grant);
        check("busy", busy, (m_owner >= 0));
        check("tx_valid", tx_valid, e_valid);
        check("req_ready", req_ready, e_ready);
        check("timeout_pulse", timeout_pulse, e_pulse);
        if (timeout_pulse) dut_pulses++;
        if (tx_valid && tx_ready) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    delivered[i]++;
                    $display("xfer t=%0t req=%0d data=0x%02h last=%0d", $time, i, tx_data, req_last[i]);
                end
            end
        end
        @(posedge clock);
        #1;
        m_owner = n_owner; m_ptr = n_ptr; m_stall = n_stall;
        phase_cyc++;
        if (xi >= 0) begin
            req_valid[xi] = 1'b0;
            req_last[xi]  = 1'b0;
            head[xi]++;
            sent[xi]++;
            if (sent[xi] == pause_at[xi]) pause_cnt[xi] = pause_len[xi];
            else if (rand_pause != 0 && !mem[xi][head[xi]-1][8] && $urandom_range(7) == 0)
                pause_cnt[xi] = $urandom_range(12, 1);
        end
        drive();
    endtask

    // Run until every queued byte is out and the model is idle
    task automatic drain(input string tag, input int budget);
        int n;
        bit done;
        n = 0;
        forever begin
            done = (m_owner < 0);
            for (int i = 0; i < NREQ; i++) if (head[i] < tail[i]) done = 0;
            if (done) break;
            if (n >= budget) begin
                check({tag, "_budget_expired"}, 1, 0);
                break;
            end
            cycle();
            n++;
        end
        for (int i = 0; i < NREQ; i++) check({tag, "_bytes"}, delivered[i], tail[i]);
    endtask

    initial begin
        new_phase();
        // Reset values hold before any clock edge
        #3;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_pulse", timeout_pulse, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Single packet from requester 1
        new_phase();
        txr_mode = 0; valid_pct = 100;
        mem[1][0] = {1'b0, 8'h48}; mem[1][1] = {1'b1, 8'h69}; tail[1] = 2;
        drive();
        cycle();
        check("single_grant", grant, 3'b010);
        drain("single", 20);

        // Round robin between requesters 0 and 1
        new_phase();
        for (int p = 0; p < 3; p++) begin
            add_packet(0, 2);
            add_packet(1, 2);
        end
        drive();
        drain("rr", 60);

        // Backpressure mid-packet
        new_phase();
        txr_mode = 2; bp_lo = 2;
        add_packet(0, 4);
        drive();
        drain("bp", 40);

        // No interleaving: requester 2 arrives during requester 0's packet
        new_phase();
        txr_mode = 0;
        add_packet(0, 4);
        add_packet(2, 2);
        start_at[2] = 2;
        drive();
        drain("nointlv", 40);

        // Owner stalls mid-packet while requester 1 waits
        new_phase();
        add_packet(0, 4);
        add_packet(1, 2);
        pause_at[0] = 1; pause_len[0] = 20; start_at[1] = 2;
        drive();
        drain("stall", 100);
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        check("stall_pulses", dut_pulses, 1);
`else
        check("stall_pulses", dut_pulses, 0);
`endif

        // Randomized traffic with backpressure and owner pauses
        new_phase();
        txr_mode = 1; valid_pct = 70; rand_pause = 1;
        for (int i = 0; i < NREQ; i++)
            for (int p = 0; p < 15; p++) add_packet(i, $urandom_range(5, 1));
        drive();
        drain("random", 4000);

        // Reset mid-packet
        new_phase();
        txr_mode = 0; valid_pct = 100; rand_pause = 0;
        add_packet(0, 4);
        drive();
        for (int n = 0; n < 20 && sent[0] < 2; n++) cycle();
        check("rstmid_reached_byte2", sent[0], 2);
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_tx_valid", tx_valid, 0);
        check("rstmid_grant", grant, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_req_ready", req_ready, 0);
        req_valid = '0; req_last = '0; req_data = '0;
        m_owner = -1; m_ptr = NREQ - 1; m_stall = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        new_phase();
        add_packet(0, 2);
        add_packet(1, 2);
        drive();
        cycle();
        check("rstmid_winner", grant, 3'b001);
        drain("rstmid", 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
